// File: rtl/error_counter_pkg.sv
// Shared types and helpers for the CDU error counter bank.
// Optional drop flag build: ERROR_COUNTER_DROP_FLAG_EN.
package error_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef enum logic {
        DIR_PLUS  = 1'b0,
        DIR_MINUS = 1'b1
    } dir_e;

    // Signed add clamped to the symmetric range -lim..+lim.
    function automatic int sat_add(
        input int a,
        input int b,
        input int lim
    );
        int s;
        s = a + b;
        if (s > lim) return lim;
        if (s < -lim) return -lim;
        return s;
    endfunction

endpackage

// File: rtl/error_counter_bank_channel.sv
// One gimbal-axis error counter: request accumulator, pulse FSM, count.
// Adds o_drop when ERROR_COUNTER_DROP_FLAG_EN is defined.
module error_counter_bank_channel
    import error_counter_pkg::*;
#(
    parameter int WIDTH   = 10,
    parameter int LIMIT   = 384,
    parameter int PEND_W  = 4,
    parameter int HOLDOFF = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_plus_req,
    input  logic             i_minus_req,
    output logic             o_pgh_p,
    output logic             o_pgh_m,
    output logic [WIDTH-1:0] o_count,
    output logic             o_sat,
    output logic             o_busy
`ifdef ERROR_COUNTER_DROP_FLAG_EN
    ,
    output logic             o_drop
`endif
);

    localparam int PMAX   = (1 << (PEND_W - 1)) - 1;
    localparam int HOLD_N = HOLDOFF - 2;
    localparam int HC_W   = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST =
        HC_W'((HOLD_N > 0) ? HOLD_N - 1 : 0);
    localparam logic signed [WIDTH-1:0] CMAX = WIDTH'(LIMIT);
    localparam logic signed [WIDTH-1:0] CMIN = WIDTH'(-LIMIT);

    state_e                    r_state;
    state_e                    w_state_nxt;
    dir_e                      r_dir;
    dir_e                      w_dir_nxt;
    logic [HC_W-1:0]           r_hold;
    logic [HC_W-1:0]           w_hold_nxt;
    logic signed [PEND_W-1:0]  r_pend;
    logic signed [PEND_W-1:0]  w_pend_nxt;
    logic signed [WIDTH-1:0]   r_count;
    logic signed [WIDTH-1:0]   w_count_nxt;
    logic                      r_sat;
    logic                      w_zero;
    logic                      w_leave;
    int                        w_consumed;
    int                        w_delta;

    // Disabled channels behave exactly like a held clear.
    assign w_zero  = i_clear | ~i_enable;
    assign w_leave = (r_state == ST_PULSE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_dir   <= DIR_PLUS;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_hold_nxt  = r_hold;
        o_pgh_p     = 1'b0;
        o_pgh_m     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_pend != '0) begin
                    w_state_nxt = ST_PULSE;
                    w_dir_nxt   = r_pend[PEND_W-1] ? DIR_MINUS : DIR_PLUS;
                end
            end
            ST_PULSE: begin
                o_pgh_p     = (r_dir == DIR_PLUS);
                o_pgh_m     = (r_dir == DIR_MINUS);
                w_hold_nxt  = '0;
                w_state_nxt = (HOLD_N > 0) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (r_hold == HOLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_zero) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_consumed = 0;
        if (w_leave) begin
            w_consumed = (r_dir == DIR_MINUS) ? -1 : 1;
        end
        w_delta     = int'(i_plus_req) - int'(i_minus_req) - w_consumed;
        w_pend_nxt  = PEND_W'(sat_add(int'(r_pend), w_delta, PMAX));
        w_count_nxt = WIDTH'(sat_add(int'(r_count),
                                     (r_dir == DIR_MINUS) ? -1 : 1,
                                     LIMIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend  <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (w_zero) begin
            r_pend  <= '0;
            r_count <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_leave) begin
                r_count <= w_count_nxt;
                r_sat   <= (w_count_nxt == CMAX) || (w_count_nxt == CMIN);
            end
        end
    end

`ifdef ERROR_COUNTER_DROP_FLAG_EN
    logic r_drop;
    int   w_pend_raw;

    assign w_pend_raw = int'(r_pend) + w_delta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else if (w_zero) begin
            r_drop <= 1'b0;
        end else if (w_pend_raw != int'(w_pend_nxt)) begin
            r_drop <= 1'b1;
        end
    end

    assign o_drop = r_drop;
`endif

    assign o_count = r_count;
    assign o_sat   = r_sat;
    assign o_busy  = (r_state != ST_IDLE) || (r_pend != '0);

endmodule

// File: rtl/error_counter_bank.sv
// Multi-channel CDU error counter bank; err_inh feeds the PIHI inhibit.
// Adds per-channel drop output when ERROR_COUNTER_DROP_FLAG_EN is defined.
module error_counter_bank
    import error_counter_pkg::*;
#(
    parameter int NCH     = 3,
    // count must hold +/-LIMIT in WIDTH-1 magnitude bits
    parameter int WIDTH   = 10,
    parameter int LIMIT   = 384,
    parameter int PEND_W  = 4,
    parameter int HOLDOFF = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       enable,
    input  logic [NCH-1:0]       clear,
    input  logic [NCH-1:0]       plus_req,
    input  logic [NCH-1:0]       minus_req,
    output logic [NCH-1:0]       pgh_p,
    output logic [NCH-1:0]       pgh_m,
    output logic [NCH*WIDTH-1:0] count,
    output logic [NCH-1:0]       sat,
    output logic [NCH-1:0]       busy,
    output logic                 err_inh
`ifdef ERROR_COUNTER_DROP_FLAG_EN
    ,
    output logic [NCH-1:0]       drop
`endif
);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        error_counter_bank_channel #(
            .WIDTH   (WIDTH),
            .LIMIT   (LIMIT),
            .PEND_W  (PEND_W),
            .HOLDOFF (HOLDOFF)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_enable    (enable[g]),
            .i_clear     (clear[g]),
            .i_plus_req  (plus_req[g]),
            .i_minus_req (minus_req[g]),
            .o_pgh_p     (pgh_p[g]),
            .o_pgh_m     (pgh_m[g]),
            .o_count     (count[g*WIDTH +: WIDTH]),
            .o_sat       (sat[g]),
            .o_busy      (busy[g])
`ifdef ERROR_COUNTER_DROP_FLAG_EN
            ,
            .o_drop      (drop[g])
`endif
        );
    end

    assign err_inh = |sat;

endmodule

// File: tb/tb_error_counter_bank.sv
// Directed self-checking bench for error_counter_bank.
module tb_error_counter_bank;

    localparam int NCH     = 3;
    localparam int WIDTH   = 10;
    localparam int LIMIT   = 384;
    localparam int PEND_W  = 4;
    localparam int HOLDOFF = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NCH-1:0]       enable;
    logic [NCH-1:0]       clear;
    logic [NCH-1:0]       plus_req;
    logic [NCH-1:0]       minus_req;
    logic [NCH-1:0]       pgh_p;
    logic [NCH-1:0]       pgh_m;
    logic [NCH*WIDTH-1:0] count;
    logic [NCH-1:0]       sat;
    logic [NCH-1:0]       busy;
    logic                 err_inh;
`ifdef ERROR_COUNTER_DROP_FLAG_EN
    logic [NCH-1:0]       drop;
`endif

    int npass = 0;
    int ntotal = 0;
    int np0 = 0;
    int nm0 = 0;
    int nother = 0;

    error_counter_bank #(
        .NCH     (NCH),
        .WIDTH   (WIDTH),
        .LIMIT   (LIMIT),
        .PEND_W  (PEND_W),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear     (clear),
        .plus_req  (plus_req),
        .minus_req (minus_req),
        .pgh_p     (pgh_p),
        .pgh_m     (pgh_m),
        .count     (count),
        .sat       (sat),
        .busy      (busy),
        .err_inh   (err_inh)
`ifdef ERROR_COUNTER_DROP_FLAG_EN
        ,
        .drop      (drop)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pgh_p[0]) np0++;
        if (pgh_m[0]) nm0++;
        if ((pgh_p[2:1] != '0) || (pgh_m[2:1] != '0)) nother++;
    end

    function automatic logic signed [WIDTH-1:0] cnt(input int ch);
        return count[ch*WIDTH +: WIDTH];
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_clear();
        clear = '1;
        step();
        clear = '0;
    endtask

    task automatic pulse_req0(input logic p, input logic m);
        plus_req[0]  = p;
        minus_req[0] = m;
        step();
        plus_req[0]  = 1'b0;
        minus_req[0] = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        steps(2);
        ntotal++;
        if ({pgh_p, pgh_m, sat, busy, err_inh} !== '0) begin
            $display("FAIL reset_flags: got %b want 0",
                     {pgh_p, pgh_m, sat, busy, err_inh});
        end else npass++;
        ntotal++;
        if (count !== '0) $display("FAIL reset_count: got %h want 0", count);
        else npass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int p0;
        int o0;
        do_clear();
        p0 = np0;
        o0 = nother;
        plus_req[0] = 1'b1;
        step();
        plus_req[0] = 1'b0;
        ntotal++;
        if (pgh_p !== 3'b000 || busy[0] !== 1'b1) begin
            $display("FAIL single_pend: pgh_p %b busy %b want 000 1",
                     pgh_p, busy[0]);
        end else npass++;
        step();
        ntotal++;
        if (pgh_p !== 3'b001) $display("FAIL single_pulse: got %b want 001", pgh_p);
        else npass++;
        step();
        ntotal++;
        if (pgh_p !== 3'b000 || cnt(0) !== 1) begin
            $display("FAIL single_count: pgh_p %b count %0d want 000 1",
                     pgh_p, cnt(0));
        end else npass++;
        steps(4);
        ntotal++;
        if (np0 - p0 !== 1 || busy[0] !== 1'b0) begin
            $display("FAIL single_once: pulses %0d busy %b want 1 0",
                     np0 - p0, busy[0]);
        end else npass++;
        ntotal++;
        if (cnt(1) !== 0 || cnt(2) !== 0 || nother !== o0) begin
            $display("FAIL single_other: c1 %0d c2 %0d pulses %0d want 0 0 0",
                     cnt(1), cnt(2), nother - o0);
        end else npass++;
    endtask

    task automatic test_burst();
        int t[$];
        int last_busy;
        bit gaps_ok;
        do_clear();
        last_busy = -1;
        gaps_ok = 1'b1;
        plus_req[0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 5) plus_req[0] = 1'b0;
            step();
            if (pgh_p[0]) t.push_back(i);
            if (busy[0]) last_busy = i;
        end
        ntotal++;
        if (t.size() != 5) $display("FAIL burst_n: got %0d want 5", t.size());
        else npass++;
        for (int k = 1; k < t.size(); k++) begin
            if (t[k] - t[k-1] != HOLDOFF) gaps_ok = 1'b0;
        end
        ntotal++;
        if (t.size() == 0 || t[0] != 1 || !gaps_ok) begin
            $display("FAIL burst_gap: first %0d gaps_ok %0b want 1 1",
                     (t.size() > 0) ? t[0] : -1, gaps_ok);
        end else npass++;
        ntotal++;
        if (cnt(0) !== 5) $display("FAIL burst_count: got %0d want 5", cnt(0));
        else npass++;
        // last pulse starts after edge 17, HOLD ends at edge 20
        ntotal++;
        if (last_busy != 19) begin
            $display("FAIL burst_busy: last busy %0d want 19", last_busy);
        end else npass++;
    endtask

    task automatic test_cancel();
        int p0;
        int m0;
        do_clear();
        p0 = np0;
        m0 = nm0;
        pulse_req0(1'b1, 1'b1);
        steps(8);
        ntotal++;
        if (np0 != p0 || nm0 != m0 || busy[0] !== 1'b0 || cnt(0) !== 0) begin
            $display("FAIL cancel: p %0d m %0d busy %b count %0d want 0 0 0 0",
                     np0 - p0, nm0 - m0, busy[0], cnt(0));
        end else npass++;
        pulse_req0(1'b0, 1'b1);
        steps(6);
        ntotal++;
        if (nm0 - m0 != 1 || np0 != p0 || cnt(0) !== -1 || sat[0] !== 1'b0) begin
            $display("FAIL minus_one: m %0d p %0d count %0d sat %b want 1 0 -1 0",
                     nm0 - m0, np0 - p0, cnt(0), sat[0]);
        end else npass++;
    endtask

    task automatic test_overflow();
        int p0;
        do_clear();
        p0 = np0;
`ifdef ERROR_COUNTER_DROP_FLAG_EN
        ntotal++;
        if (drop[0] !== 1'b0) $display("FAIL drop_init: got %b want 0", drop[0]);
        else npass++;
`endif
        plus_req[0] = 1'b1;
        steps(10);
        plus_req[0] = 1'b0;
        steps(50);
        // two pulses are consumed while the burst arrives; pend tops at 7
        // on the 10th request, which is the one dropped
        ntotal++;
        if (np0 - p0 != 9 || cnt(0) !== 9) begin
            $display("FAIL overflow: pulses %0d count %0d want 9 9",
                     np0 - p0, cnt(0));
        end else npass++;
`ifdef ERROR_COUNTER_DROP_FLAG_EN
        ntotal++;
        if (drop[0] !== 1'b1) $display("FAIL drop_set: got %b want 1", drop[0]);
        else npass++;
        do_clear();
        ntotal++;
        if (drop[0] !== 1'b0) $display("FAIL drop_clear: got %b want 0", drop[0]);
        else npass++;
`endif
    endtask

    task automatic test_saturation();
        int p0;
        do_clear();
        p0 = np0;
        for (int i = 0; i < 390; i++) begin
            pulse_req0(1'b1, 1'b0);
            steps(3);
        end
        steps(6);
        ntotal++;
        if (np0 - p0 != 390 || cnt(0) !== LIMIT) begin
            $display("FAIL sat_count: pulses %0d count %0d want 390 384",
                     np0 - p0, cnt(0));
        end else npass++;
        ntotal++;
        if (sat !== 3'b001 || err_inh !== 1'b1) begin
            $display("FAIL sat_flag: sat %b inh %b want 001 1", sat, err_inh);
        end else npass++;
        pulse_req0(1'b0, 1'b1);
        steps(6);
        ntotal++;
        if (cnt(0) !== LIMIT - 1 || sat !== 3'b000 || err_inh !== 1'b0) begin
            $display("FAIL unsat: count %0d sat %b inh %b want 383 000 0",
                     cnt(0), sat, err_inh);
        end else npass++;
    endtask

    task automatic test_clear_pulse();
        int p0;
        do_clear();
        pulse_req0(1'b1, 1'b0);
        steps(6);
        pulse_req0(1'b1, 1'b0);
        step();
        clear[0] = 1'b1;
        #1;
        ntotal++;
        if (pgh_p[0] !== 1'b1 || cnt(0) !== 1) begin
            $display("FAIL clr_pulse_vis: pgh %b count %0d want 1 1",
                     pgh_p[0], cnt(0));
        end else npass++;
        step();
        clear[0] = 1'b0;
        ntotal++;
        if (cnt(0) !== 0 || sat[0] !== 1'b0 || busy[0] !== 1'b0) begin
            $display("FAIL clr_count: count %0d sat %b busy %b want 0 0 0",
                     cnt(0), sat[0], busy[0]);
        end else npass++;
        p0 = np0;
        steps(8);
        ntotal++;
        if (np0 != p0 || cnt(0) !== 0) begin
            $display("FAIL clr_after: pulses %0d count %0d want 0 0",
                     np0 - p0, cnt(0));
        end else npass++;
    endtask

    task automatic test_enable();
        int p0;
        do_clear();
        pulse_req0(1'b1, 1'b0);
        steps(6);
        enable[0] = 1'b0;
        p0 = np0;
        plus_req = 3'b011;
        steps(8);
        plus_req = 3'b000;
        ntotal++;
        if (np0 != p0 || cnt(0) !== 0 || busy[0] !== 1'b0) begin
            $display("FAIL disable: pulses %0d count %0d busy %b want 0 0 0",
                     np0 - p0, cnt(0), busy[0]);
        end else npass++;
        steps(30);
        ntotal++;
        if (cnt(1) !== 8 || cnt(2) !== 0) begin
            $display("FAIL indep: c1 %0d c2 %0d want 8 0", cnt(1), cnt(2));
        end else npass++;
        enable[0] = 1'b1;
    endtask

    task automatic test_reset_midpulse();
        do_clear();
        pulse_req0(1'b1, 1'b0);
        steps(6);
        pulse_req0(1'b1, 1'b0);
        step();
        ntotal++;
        if (pgh_p[0] !== 1'b1 || cnt(0) !== 1) begin
            $display("FAIL rst_setup: pgh %b count %0d want 1 1", pgh_p[0], cnt(0));
        end else npass++;
        rst_n = 1'b0;
        #1;
        ntotal++;
        if (pgh_p !== '0 || pgh_m !== '0 || count !== '0 || busy !== '0) begin
            $display("FAIL rst_async: pgh %b/%b count %h busy %b want 0",
                     pgh_p, pgh_m, count, busy);
        end else npass++;
        step();
        rst_n = 1'b1;
        steps(4);
        ntotal++;
        if (pgh_p !== '0 || count !== '0 || busy !== '0) begin
            $display("FAIL rst_after: pgh %b count %h busy %b want 0",
                     pgh_p, count, busy);
        end else npass++;
    endtask

    initial begin
        enable    = '1;
        clear     = '0;
        plus_req  = '0;
        minus_req = '0;
        test_reset();
        test_single();
        test_burst();
        test_cancel();
        test_overflow();
        test_saturation();
        test_clear_pulse();
        test_enable();
        test_reset_midpulse();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
